// File: rtl/fv_pkg.sv
// Shared FV scheme definitions: default moduli, decode FSM states and
// width helpers for the scale-and-round decode path.
package fv_pkg;

   localparam int FV_N_DEF  = 4;
   localparam int FV_QW_DEF = 5;
   localparam int FV_Q_DEF  = 29;
   localparam int FV_T_DEF  = 4;

   typedef enum logic [1:0] {IDLE, DIV, OUT} fv_dec_state_e;

   // Quotient bits needed to hold floor((x*T + Q/2)/Q), which can reach T.
   function automatic int fv_quw(input int t);
      return $clog2(t + 1);
   endfunction

   // Numerator width for x*T + floor(Q/2) with x < Q.
   function automatic int fv_numw(input int qw, input int t);
      return qw + $clog2(t + 1);
   endfunction

endpackage

// File: rtl/fv_const_div.sv
// Restoring divider by a constant divisor, one quotient bit per cycle,
// MSB first. The final quotient is presented on the same cycle as done.
module fv_const_div #(
   parameter int DIVISOR = 29,
   parameter int QUW     = 3,
   parameter int NUMW    = 8
) (
   input  logic            clk,
   input  logic            s_rst_n,
   input  logic            start,
   input  logic [NUMW-1:0] num,
   output logic            busy,
   output logic            done,
   output logic [QUW-1:0]  quotient
);

   localparam int KW = (QUW > 1) ? $clog2(QUW) : 1;
   localparam logic [NUMW-1:0] DIV_C = NUMW'(DIVISOR);

   logic [NUMW-1:0] rem_q, rem_d, dsh;
   logic [QUW-1:0]  quo_q, quo_d;
   logic [KW-1:0]   k_q, k_d;
   logic            busy_q, busy_d;

   // One restoring step per cycle: trial-subtract DIVISOR<<k from the remainder.
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      k_d    = k_q;
      busy_d = busy_q;
      done   = 1'b0;
      dsh    = DIV_C << k_q;
      if (start) begin
         rem_d  = num;
         quo_d  = '0;
         k_d    = KW'(QUW - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (rem_q >= dsh) begin
            rem_d      = rem_q - dsh;
            quo_d[k_q] = 1'b1;
         end
         if (k_q == '0) begin
            busy_d = 1'b0;
            done   = 1'b1;
         end else begin
            k_d = k_q - KW'(1);
         end
      end
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         k_q    <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         k_q    <= k_d;
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign quotient = quo_d;

endmodule

// File: rtl/fv_scale_round.sv
// FV decode stage: m = round(T*x/Q) mod T over a framed coefficient stream,
// with a bit-serial divider and full valid/ready handshakes on both sides.
module fv_scale_round
   import fv_pkg::*;
#(
   parameter int N  = FV_N_DEF,
   parameter int QW = FV_QW_DEF,
   parameter int Q  = FV_Q_DEF,
   parameter int T  = FV_T_DEF,
   parameter int TW = $clog2(T)
) (
   input  logic          clk,
   input  logic          s_rst_n,
   input  logic          c_vld,
   output logic          c_rdy,
   input  logic          c_last,
   input  logic [QW-1:0] c_data,
   output logic          m_vld,
   input  logic          m_rdy,
   output logic          m_last,
   output logic [TW-1:0] m_data,
   output logic          err
);

   localparam int QUW  = fv_quw(T);
   localparam int NUMW = fv_numw(QW, T);
   localparam int CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [QW-1:0]   Q_C    = QW'(Q);
   localparam logic [NUMW-1:0] T_C    = NUMW'(T);
   localparam logic [NUMW-1:0] HALF_C = NUMW'(Q / 2);
   localparam logic [QUW-1:0]  TQ_C   = QUW'(T);
   localparam logic [CW-1:0]   LAST_C = CW'(N - 1);

   fv_dec_state_e   state_q, state_d;
   logic            vld_q, vld_d;
   logic            last_q, last_d;
   logic [TW-1:0]   data_q, data_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]   xr;
   logic [NUMW-1:0] num;
   logic            accept, div_busy, div_done;
   logic [QUW-1:0]  div_quo;

   // Input is held to IDLE and forced low during reset so nothing is accepted.
   assign c_rdy  = s_rst_n && (state_q == IDLE) && !div_busy;
   assign accept = c_vld && c_rdy;

   // Single conditional subtract brings x into [0, Q); then scale and add Q/2.
   always_comb begin
      xr  = (c_data >= Q_C) ? c_data - Q_C : c_data;
      num = NUMW'(xr) * T_C + HALF_C;
   end

   fv_const_div #(
      .DIVISOR (Q),
      .QUW     (QUW),
      .NUMW    (NUMW)
   ) u_div (
      .clk      (clk),
      .s_rst_n  (s_rst_n),
      .start    (accept),
      .num      (num),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   // Handshake FSM, output register and framing check.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = DIV;
            last_d  = c_last;
         end
         DIV: if (div_done) begin
            state_d = OUT;
            // y == T is the rounding wrap back to zero.
            data_d  = (div_quo == TQ_C) ? '0 : div_quo[TW-1:0];
         end
         OUT: if (m_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      vld_d = (state_d == OUT);
      if (accept) begin
         if (c_last) begin
            if (cnt_q != LAST_C) err_d = 1'b1;
            cnt_d = '0;
         end else if (cnt_q == LAST_C) begin
            err_d = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_vld  = vld_q;
   assign m_last = last_q;
   assign m_data = data_q;
   assign err    = err_q;

endmodule
